// File: rtl/uart_rx.sv
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 serial receiver with 3-sample mid-bit majority vote,
//             framing-error detection and line-break recovery.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 os_tick,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] M0       = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] M1       = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] M2       = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] LAST     = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t               state;
    logic                 sync_meta;
    logic                 rxs;
    logic [TW-1:0]        tick_cnt;
    logic [TW-1:0]        tick_next;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 s0;
    logic                 s1;
    logic                 maj;

    // tick_cnt holds the index of the last processed tick; the start-detect
    // tick is index 0, so each bit spans indices 0..OVERSAMPLE-1.
    always_comb begin
        tick_next = (tick_cnt == LAST) ? '0 : tick_cnt + TW'(1);
        maj       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    end

    assign rx_busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync_meta <= rx_serial;
            rxs       <= sync_meta;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (os_tick) begin
                if (state == START || state == DATA || state == STOP) begin
                    tick_cnt <= tick_next;
                    if (tick_next == M0) s0 <= rxs;
                    if (tick_next == M1) s1 <= rxs;
                end

                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick_next == M2 && maj) begin
                            state <= IDLE;
                        end else if (tick_next == LAST) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (tick_next == M2) begin
                            shreg <= {maj, shreg[DATA_BITS-1:1]};
                        end
                        if (tick_next == LAST) begin
                            if (bit_cnt == LAST_BIT) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end
                    end
                    STOP: begin
                        // Leaving at mid-stop-bit lets an immediate next start edge be caught.
                        if (tick_next == M2) begin
                            if (maj) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                                state    <= IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_IDLE;
                            end
                        end
                    end
                    WAIT_IDLE: begin
                        if (rxs) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module   : tb_uart_rx
//  Brief    : Directed table-driven bench for uart_rx (OVERSAMPLE=16, 8N1).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int BIT = 64;  // clocks per bit: 16 os_ticks x 4 clocks

    logic       clk = 1'b0;
    logic       rst_n;
    logic       os_tick;
    logic       rx_serial;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;
    int ecount   = 0;
    logic [7:0] rxq[$];
    logic prev_busy = 1'b0;
    logic busy_seen = 1'b0;
    logic [1:0] div = 2'd0;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .os_tick   (os_tick),
        .rx_serial (rx_serial),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div     <= div + 2'd1;
        os_tick <= (div == 2'd3);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid || frame_err) check("valid_err_exclusive", {31'd0, rx_valid & frame_err}, 0);
            if (rx_valid) begin
                rxq.push_back(rx_data);
                vcount++;
                check("busy_low_at_valid", {31'd0, rx_busy}, 0);
                check("busy_high_before_valid", {31'd0, prev_busy}, 1);
            end
            if (frame_err) ecount++;
            if (rx_busy) busy_seen = 1'b1;
        end
        prev_busy = rx_busy;
    end

    task automatic send_bit(input logic v, input int clocks);
        rx_serial = v;
        repeat (clocks) @(negedge clk);
    endtask

    // spike_bit >= 0 inverts one os_tick period near mid-bit of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int spike_bit);
        send_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                send_bit(d[i], 32);
                send_bit(~d[i], 4);
                send_bit(d[i], 28);
            end else begin
                send_bit(d[i], BIT);
            end
        end
        send_bit(stop, BIT);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         spike;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int v0, e0, q0;
        vecs[0] = '{8'hA5, 1'b1, -1, 8'hA5, 1, 0};
        vecs[1] = '{8'h01, 1'b1, -1, 8'h01, 1, 0};
        vecs[2] = '{8'h55, 1'b1,  3, 8'h55, 1, 0};
        vecs[3] = '{8'h80, 1'b1, -1, 8'h80, 1, 0};
        vecs[4] = '{8'h7E, 1'b0, -1, 8'h80, 0, 1};
        vecs[5] = '{8'h5A, 1'b1,  6, 8'h5A, 1, 0};

        rst_n     = 1'b0;
        rx_serial = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 0);
        check("reset_rx_valid", {31'd0, rx_valid}, 0);
        check("reset_rx_busy", {31'd0, rx_busy}, 0);
        check("reset_frame_err", {31'd0, frame_err}, 0);
        rst_n = 1'b1;
        send_bit(1'b1, 2 * BIT);

        for (int i = 0; i < 6; i++) begin
            v0 = vcount;
            e0 = ecount;
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].spike);
            send_bit(1'b1, 2 * BIT);
            check($sformatf("vec%0d_valid_count", i), vcount - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_err_count", i), ecount - e0, vecs[i].exp_err);
            check($sformatf("vec%0d_rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_data});
            check($sformatf("vec%0d_idle_busy", i), {31'd0, rx_busy}, 0);
        end

        // Short low glitch: false start, no outputs.
        v0 = vcount; e0 = ecount; busy_seen = 1'b0;
        send_bit(1'b0, 16);
        send_bit(1'b1, 2 * BIT);
        check("glitch_busy_seen", {31'd0, busy_seen}, 1);
        check("glitch_valid_count", vcount - v0, 0);
        check("glitch_err_count", ecount - e0, 0);
        check("glitch_rx_data", {24'd0, rx_data}, 32'h5A);
        check("glitch_back_idle", {31'd0, rx_busy}, 0);

        // Back-to-back frames with no idle gap.
        v0 = vcount; e0 = ecount; q0 = rxq.size();
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        send_bit(1'b1, 2 * BIT);
        check("b2b_valid_count", vcount - v0, 3);
        check("b2b_err_count", ecount - e0, 0);
        if (rxq.size() >= q0 + 3) begin
            check("b2b_byte0", {24'd0, rxq[q0]}, 32'h00);
            check("b2b_byte1", {24'd0, rxq[q0+1]}, 32'hFF);
            check("b2b_byte2", {24'd0, rxq[q0+2]}, 32'h3C);
        end

        // Bad stop bit followed by a held-low line (break).
        v0 = vcount; e0 = ecount;
        send_frame(8'h81, 1'b0, -1);
        send_bit(1'b0, 3 * 10 * BIT);
        check("break_busy_held", {31'd0, rx_busy}, 1);
        check("break_err_count", ecount - e0, 1);
        check("break_valid_count", vcount - v0, 0);
        check("break_rx_data", {24'd0, rx_data}, 32'h3C);
        send_bit(1'b1, 2 * BIT);
        check("break_recovered_idle", {31'd0, rx_busy}, 0);
        v0 = vcount;
        send_frame(8'h42, 1'b1, -1);
        send_bit(1'b1, 2 * BIT);
        check("post_break_valid_count", vcount - v0, 1);
        check("post_break_rx_data", {24'd0, rx_data}, 32'h42);

        // Reset asserted during data bit 4 of 0xC3.
        send_bit(1'b0, BIT);
        send_bit(1'b1, BIT);
        send_bit(1'b1, BIT);
        send_bit(1'b0, BIT);
        send_bit(1'b0, BIT);
        send_bit(1'b0, 32);
        rst_n = 1'b0;
        #1;
        check("midreset_rx_data", {24'd0, rx_data}, 0);
        check("midreset_rx_valid", {31'd0, rx_valid}, 0);
        check("midreset_rx_busy", {31'd0, rx_busy}, 0);
        check("midreset_frame_err", {31'd0, frame_err}, 0);
        rx_serial = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        v0 = vcount; e0 = ecount;
        send_bit(1'b1, 2 * BIT);
        send_frame(8'h99, 1'b1, -1);
        send_bit(1'b1, 2 * BIT);
        check("post_reset_valid_count", vcount - v0, 1);
        check("post_reset_err_count", ecount - e0, 0);
        check("post_reset_rx_data", {24'd0, rx_data}, 32'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
